// File: rtl/bit_reverse_reorder.sv
// rtl/bit_reverse_reorder.sv - ping-pong reorder of a bit-reversed FFT frame into natural order
// Optional truncated-frame error pulse: define REORDER_ERR_EN.
module bit_reverse_reorder #(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
`ifdef REORDER_ERR_EN
    output logic             err,
`endif
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);
    localparam int LOG_N = $clog2(N);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;
    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

    logic [2*WIDTH-1:0] mem [0:2*N-1];
    logic [2*WIDTH-1:0] rd_q;
    logic [LOG_N-1:0]   wr_cnt;
    logic [LOG_N-1:0]   wr_addr;
    logic [LOG_N-1:0]   rd_cnt;
    logic               wr_bank;
    logic               rd_bank;
    logic [1:0]         full;
    logic [1:0]         full_next;
    logic [0:0]         state;
    logic               rd_issue;
    logic               wr_done;
    logic               rd_done;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = a[LOG_N-1-i];
        end
        return r;
    endfunction

    assign wr_addr  = bitrev(wr_cnt);
    assign wr_done  = di_en && (wr_cnt == LAST);
    assign rd_issue = (state == ST_READ);
    assign rd_done  = rd_issue && (rd_cnt == LAST);

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (di_en) begin
            mem[{wr_bank, wr_addr}] <= {di_re, di_im};
        end
        if (rd_issue) begin
            rd_q <= mem[{rd_bank, rd_cnt}];
        end
    end

    // A frame that drops di_en early restarts at address 0 and never marks its bank full.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (di_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
        end else begin
            wr_cnt <= '0;
        end
    end

    // Writer and reader always address different banks, so set and clear never collide.
    always_comb begin
        full_next = full;
        if (rd_done) begin
            full_next[rd_bank] = 1'b0;
        end
        if (wr_done) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            full <= full_next;
        end
    end

    // rd_bank only toggles at frame end, so it also remembers which bank is due next.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (state == ST_IDLE) begin
            rd_cnt <= '0;
            if (full != 2'b00) begin
                state   <= ST_READ;
                rd_bank <= full[rd_bank] ? rd_bank : ~rd_bank;
            end
        end else begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_done) begin
                rd_bank <= ~rd_bank;
                if (!full[~rd_bank]) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            do_en <= 1'b0;
        end else begin
            do_en <= rd_issue;
        end
    end

    assign do_re = do_en ? rd_q[2*WIDTH-1:WIDTH] : '0;
    assign do_im = do_en ? rd_q[WIDTH-1:0]       : '0;

`ifdef REORDER_ERR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= !di_en && (wr_cnt != '0);
        end
    end
`endif

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// tb/tb_bit_reverse_reorder.sv - self-checking bench for bit_reverse_reorder (N=8 and N=64 instances)
module tb_bit_reverse_reorder;
    localparam int W    = 16;
    localparam int MAXC = 4096;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset;
    logic         a_en, ao_en, b_en, bo_en;
    logic [W-1:0] a_re, a_im, ao_re, ao_im;
    logic [W-1:0] b_re, b_im, bo_re, bo_im;
`ifdef REORDER_ERR_EN
    logic         a_err, b_err;
`endif

    bit_reverse_reorder #(.N(8), .WIDTH(W)) dut8 (
        .clock(clock), .reset(reset),
        .di_en(a_en), .di_re(a_re), .di_im(a_im),
`ifdef REORDER_ERR_EN
        .err(a_err),
`endif
        .do_en(ao_en), .do_re(ao_re), .do_im(ao_im)
    );

    bit_reverse_reorder #(.N(64), .WIDTH(W)) dut64 (
        .clock(clock), .reset(reset),
        .di_en(b_en), .di_re(b_re), .di_im(b_im),
`ifdef REORDER_ERR_EN
        .err(b_err),
`endif
        .do_en(bo_en), .do_re(bo_re), .do_im(bo_im)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int brev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    // Reference model: a frame completed at edge e shows bin k right after edge e+2+k.
    int           e_cnt = 0;
    logic         exp_en [MAXC];
    logic [W-1:0] exp_re [MAXC];
    logic [W-1:0] exp_im [MAXC];
    logic [W-1:0] buf8_re [8], buf8_im [8];
    logic [W-1:0] buf64_re[64], buf64_im[64];
    logic [W-1:0] q_re[$], q_im[$];
    int           run8 = 0, run64 = 0;

    always @(posedge clock) begin
        e_cnt++;
        if (reset) begin
            run8 = 0;
            run64 = 0;
            for (int i = e_cnt; i < MAXC; i++) begin
                exp_en[i] = 1'b0; exp_re[i] = '0; exp_im[i] = '0;
            end
            q_re.delete();
            q_im.delete();
        end else begin
            if (a_en) begin
                buf8_re[run8] = a_re;
                buf8_im[run8] = a_im;
                run8++;
                if (run8 == 8) begin
                    for (int k = 0; k < 8; k++) begin
                        if (e_cnt + 2 + k < MAXC) begin
                            exp_en[e_cnt+2+k] = 1'b1;
                            exp_re[e_cnt+2+k] = buf8_re[brev(k, 3)];
                            exp_im[e_cnt+2+k] = buf8_im[brev(k, 3)];
                        end
                    end
                    run8 = 0;
                end
            end else begin
                run8 = 0;
            end
            if (b_en) begin
                buf64_re[run64] = b_re;
                buf64_im[run64] = b_im;
                run64++;
                if (run64 == 64) begin
                    for (int k = 0; k < 64; k++) begin
                        q_re.push_back(buf64_re[brev(k, 6)]);
                        q_im.push_back(buf64_im[brev(k, 6)]);
                    end
                    run64 = 0;
                end
            end else begin
                run64 = 0;
            end
        end
    end

    logic chk_on = 1'b0;
    int   a_outs = 0, b_outs = 0, b_run = 0, b_max = 0;

    always @(negedge clock) begin
        if (chk_on) begin
            chk("a_en", ao_en, exp_en[e_cnt]);
            chk("a_re", ao_re, exp_re[e_cnt]);
            chk("a_im", ao_im, exp_im[e_cnt]);
            if (ao_en) a_outs++;
            if (bo_en) begin
                b_outs++;
                b_run++;
                if (b_run > b_max) b_max = b_run;
                if (q_re.size() == 0) begin
                    chk("b_spurious", 1, 0);
                end else begin
                    chk("b_re", bo_re, q_re.pop_front());
                    chk("b_im", bo_im, q_im.pop_front());
                end
            end else begin
                b_run = 0;
            end
        end
    end

    task automatic idle8(input int n);
        repeat (n) begin
            @(negedge clock);
            a_en = 1'b0; a_re = '0; a_im = '0;
        end
    endtask

    task automatic send8(input int base, input int len);
        for (int p = 0; p < len; p++) begin
            @(negedge clock);
            a_en = 1'b1;
            a_re = W'(base + p);
            a_im = W'(-(base + p));
        end
    endtask

    typedef struct {
        logic [W-1:0] in_re;
        logic [W-1:0] in_im;
        logic [W-1:0] exp_re;
        logic [W-1:0] exp_im;
    } vec_t;

    vec_t vec[8];
    int   rev8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int   base_outs;
    int   waited;

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_en[i] = 1'b0; exp_re[i] = '0; exp_im[i] = '0;
        end
        for (int p = 0; p < 8; p++) begin
            vec[p].in_re  = W'(p);
            vec[p].in_im  = W'(-p);
            vec[p].exp_re = W'(rev8[p]);
            vec[p].exp_im = W'(-rev8[p]);
        end
        reset = 1'b1;
        a_en = 1'b0; a_re = '0; a_im = '0;
        b_en = 1'b0; b_re = '0; b_im = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_a_en", ao_en, 0);
        chk("rst_a_re", ao_re, 0);
        chk("rst_a_im", ao_im, 0);
        chk("rst_b_en", bo_en, 0);
        chk_on = 1'b1;

        // single frame from the table, with exact latency
        for (int p = 0; p < 8; p++) begin
            @(negedge clock);
            a_en = 1'b1; a_re = vec[p].in_re; a_im = vec[p].in_im;
        end
        idle8(1);
        chk("t1_lat0", ao_en, 0);
        idle8(1);
        chk("t1_lat1", ao_en, 0);
        for (int k = 0; k < 8; k++) begin
            idle8(1);
            chk("t1_en", ao_en, 1);
            chk("t1_re", ao_re, vec[k].exp_re);
            chk("t1_im", ao_im, vec[k].exp_im);
        end
        idle8(1);
        chk("t1_end", ao_en, 0);
        idle8(8);

        // three back-to-back frames
        base_outs = a_outs;
        for (int f = 0; f < 3; f++) send8(16 * f, 8);
        idle8(30);
        chk("t2_count", a_outs - base_outs, 24);

        // truncated frame then a full frame
        base_outs = a_outs;
        send8(8'h50, 5);
        idle8(1);
        idle8(1);
`ifdef REORDER_ERR_EN
        chk("t3_err_hi", a_err, 1);
`endif
        idle8(1);
`ifdef REORDER_ERR_EN
        chk("t3_err_lo", a_err, 0);
`endif
        send8(8'h60, 8);
        idle8(20);
        chk("t3_count", a_outs - base_outs, 8);

        // two frames with a 20-cycle gap
        base_outs = a_outs;
        send8(8'h70, 8);
        idle8(20);
        send8(8'h90, 8);
        idle8(20);
        chk("t4_count", a_outs - base_outs, 16);

        // reset on the third output of a burst
        send8(8'h30, 8);
        waited = 0;
        while (!ao_en && waited < 20) begin
            idle8(1);
            waited++;
        end
        chk("t5_burst_seen", ao_en, 1);
        idle8(2);
        reset = 1'b1;
        idle8(1);
        reset = 1'b0;
        chk("t5_rst_en", ao_en, 0);
        chk("t5_rst_re", ao_re, 0);
        base_outs = a_outs;
        idle8(12);
        chk("t5_no_stale", a_outs - base_outs, 0);
        send8(8'hA0, 8);
        idle8(20);
        chk("t5_after", a_outs - base_outs, 8);

        // N=64, ten back-to-back random frames
        for (int f = 0; f < 10; f++) begin
            for (int p = 0; p < 64; p++) begin
                @(negedge clock);
                b_en = 1'b1;
                b_re = W'($urandom);
                b_im = W'($urandom);
            end
        end
        repeat (100) begin
            @(negedge clock);
            b_en = 1'b0; b_re = '0; b_im = '0;
        end
        chk("t6_drain", q_re.size(), 0);
        chk("t6_run", b_max, 640);
        chk("t6_total", b_outs, 640);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
